// File: rtl/player_leds.sv
// rtl/player_leds.sv - media player button front end, state machine and status LEDs
module player_leds #(
    parameter int N_LEDS          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_HALF      = 12500000,
    parameter int ACT_PULSE       = 5000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              play_pause,
    input  logic              stop,
    output logic [N_LEDS:1]   saida,
    output logic [1:0]        estado
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int AW = $clog2(ACT_PULSE + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_HALF - 1);
    localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_PULSE);

    // XOR mask turning "lit" into the physical drive level
    localparam logic [N_LEDS:1] POL       = {N_LEDS{ACTIVE_LOW}};
    localparam logic [N_LEDS:1] RESET_LIT = {{(N_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_PLAYING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    // Button index 0 is play_pause, index 1 is stop
    logic [1:0]    meta_q, sync_q;
    logic [1:0]    deb_q, deb_d, deb_dly_q;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    state_t        state_q, state_d;
    logic [AW-1:0] act_q, act_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [N_LEDS:1] lit_d, saida_q;

    logic pp_evt, st_evt;

    // Two-flop synchronizers for both raw buttons
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {stop, play_pause};
            sync_q <= meta_q;
        end
    end

    // Debounce: a new level is accepted after DEBOUNCE_CYCLES disagreeing samples in a row
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Debounced levels, their one-cycle-old copy and the run counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_q     <= '0;
            deb_dly_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign pp_evt = deb_q[0] & ~deb_dly_q[0];
    assign st_evt = deb_q[1] & ~deb_dly_q[1];

    // Player state, activity pulse and pause blink next-state logic; stop beats play_pause
    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (act_q != '0) begin
            act_d = act_q - AW'(1);
        end
        if (state_q == ST_PAUSED) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        if (st_evt) begin
            state_d = ST_STOPPED;
            act_d   = ACT_LOAD;
        end else if (pp_evt) begin
            act_d = ACT_LOAD;
            case (state_q)
                ST_STOPPED: state_d = ST_PLAYING;
                ST_PLAYING: begin
                    state_d     = ST_PAUSED;
                    blink_cnt_d = '0;
                    blink_on_d  = 1'b1;
                end
                ST_PAUSED:  state_d = ST_PLAYING;
                default:    state_d = ST_STOPPED;
            endcase
        end
    end

    // State, activity and blink registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_STOPPED;
            act_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Which LEDs should be lit, derived from the registered state
    always_comb begin
        lit_d    = '0;
        lit_d[1] = (state_q == ST_STOPPED);
        lit_d[2] = (state_q == ST_PLAYING);
        lit_d[3] = (state_q == ST_PAUSED) && blink_on_q;
        lit_d[4] = (act_q != '0);
    end

    // Registered LED drive with polarity applied
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida_q <= POL ^ RESET_LIT;
        end else begin
            saida_q <= POL ^ lit_d;
        end
    end

    assign saida  = saida_q;
    assign estado = state_q;

endmodule
